// File: rtl/mmcm_drp_ctrl.sv
`timescale 1ns / 1ps
// MMCME2 runtime reconfiguration sequencer: masked DRP read-modify-writes
// performed while the MMCM is held in reset, followed by a lock wait.
module mmcm_drp_ctrl #(
    parameter int unsigned RST_HOLD     = 4,
    parameter int unsigned DRDY_TIMEOUT = 64,
    parameter int unsigned LOCK_TIMEOUT = 65536
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [6:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic [15:0] cfg_mask,
    input  logic        cfg_last,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        clk_ok
);

    typedef enum logic [2:0] {
        StIdle, StHold, StWaitWord, StRd, StRdWait, StWr, StWrWait, StWaitLock
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        lock_meta_q, lock_s_q;
    logic [15:0] data_q, mask_q, merged_q;
    logic        last_q;
    logic        mmcm_rst_q, mmcm_rst_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        clk_ok_q;
    logic        den_q, den_d;
    logic        dwe_q, dwe_d;
    logic [6:0]  daddr_q, daddr_d;
    logic [15:0] di_q, di_d;
    logic        cnt_zero;
    logic        handshake;

    assign cnt_zero  = (cnt_q == 32'd0);
    assign handshake = (state_q == StWaitWord) && cfg_valid;

    // State, datapath latches and registered outputs
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 32'd0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            data_q      <= 16'd0;
            mask_q      <= 16'd0;
            merged_q    <= 16'd0;
            last_q      <= 1'b0;
            mmcm_rst_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_ok_q    <= 1'b0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= 7'd0;
            di_q        <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lock_meta_q <= mmcm_locked;
            lock_s_q    <= lock_meta_q;
            mmcm_rst_q  <= mmcm_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clk_ok_q    <= lock_s_q && (state_q == StIdle) && !mmcm_rst_q;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
            if (handshake) begin
                data_q <= cfg_data;
                mask_q <= cfg_mask;
                last_q <= cfg_last;
            end
            if ((state_q == StRdWait) && drp_drdy) begin
                merged_q <= (drp_do & mask_q) | (data_q & ~mask_q);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    state_d = StHold;
                    cnt_d   = RST_HOLD - 1;
                end
            end
            StHold: begin
                if (cnt_zero) state_d = StWaitWord;
                else          cnt_d   = cnt_q - 32'd1;
            end
            StWaitWord: begin
                if (cfg_valid) state_d = StRd;
            end
            StRd: begin
                // Read den is already on the pins this cycle, so one tick is used up
                state_d = StRdWait;
                cnt_d   = DRDY_TIMEOUT - 1;
            end
            StRdWait: begin
                if (drp_drdy)      state_d = StWr;
                else if (cnt_zero) state_d = StIdle;
                else               cnt_d   = cnt_q - 32'd1;
            end
            StWr: begin
                // Write den appears on entry to StWrWait, hence the full count
                state_d = StWrWait;
                cnt_d   = DRDY_TIMEOUT;
            end
            StWrWait: begin
                if (drp_drdy) begin
                    if (last_q) begin
                        state_d = StWaitLock;
                        cnt_d   = LOCK_TIMEOUT - 1;
                    end else begin
                        state_d = StWaitWord;
                    end
                end else if (cnt_zero) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            StWaitLock: begin
                if (lock_s_q)      state_d = StIdle;
                else if (cnt_zero) state_d = StIdle;
                else               cnt_d   = cnt_q - 32'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        mmcm_rst_d = mmcm_rst_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        den_d      = 1'b0;
        dwe_d      = 1'b0;
        daddr_d    = daddr_q;
        di_d       = di_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_valid) mmcm_rst_d = 1'b1;
            end
            StWaitWord: begin
                if (cfg_valid) begin
                    den_d   = 1'b1;
                    daddr_d = cfg_addr;
                end
            end
            StRdWait: begin
                if (!drp_drdy && cnt_zero) err_d = 1'b1;
            end
            StWr: begin
                den_d = 1'b1;
                dwe_d = 1'b1;
                di_d  = merged_q;
            end
            StWrWait: begin
                if (drp_drdy && last_q)     mmcm_rst_d = 1'b0;
                else if (!drp_drdy && cnt_zero) err_d  = 1'b1;
            end
            StWaitLock: begin
                if (lock_s_q) begin
                    done_d = 1'b1;
                end else if (cnt_zero) begin
                    err_d      = 1'b1;
                    mmcm_rst_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign cfg_ready = (state_q == StWaitWord);
    assign drp_den   = den_q;
    assign drp_dwe   = dwe_q;
    assign drp_daddr = daddr_q;
    assign drp_di    = di_q;
    assign mmcm_rst  = mmcm_rst_q;
    assign done      = done_q;
    assign err       = err_q;
    assign clk_ok    = clk_ok_q;

endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
`timescale 1ns / 1ps
// Bench for mmcm_drp_ctrl: DRP slave and MMCM lock behavioural models plus a
// register-image reference model of the masked read-modify-write sequence.
module tb_mmcm_drp_ctrl;
    localparam int unsigned RST_HOLD     = 4;
    localparam int unsigned DRDY_TIMEOUT = 64;
    localparam int unsigned LOCK_TIMEOUT = 65536;

    logic        clkin = 1'b0;
    logic        rst;
    logic        cfg_valid, cfg_ready, cfg_last;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_data, cfg_mask;
    logic        drp_den, drp_dwe, drp_drdy;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di, drp_do;
    logic        mmcm_rst, mmcm_locked;
    logic        busy, done, err, clk_ok;

    mmcm_drp_ctrl #(
        .RST_HOLD    (RST_HOLD),
        .DRDY_TIMEOUT(DRDY_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clkin      (clkin),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_mask   (cfg_mask),
        .cfg_last   (cfg_last),
        .drp_den    (drp_den),
        .drp_dwe    (drp_dwe),
        .drp_daddr  (drp_daddr),
        .drp_di     (drp_di),
        .drp_do     (drp_do),
        .drp_drdy   (drp_drdy),
        .mmcm_rst   (mmcm_rst),
        .mmcm_locked(mmcm_locked),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .clk_ok     (clk_ok)
    );

    always #4 clkin = ~clkin;

    int cyc = 0;
    always @(posedge clkin) cyc <= cyc + 1;

    typedef struct {
        bit          we;
        logic [6:0]  addr;
        logic [15:0] di;
        int          cyc;
        logic        rst_hi;
    } txn_t;

    txn_t        obs[$];
    int          drdy_q[$];
    logic [15:0] mem[128];
    logic [15:0] exp_mem[128];
    int          drdy_dly = 2;
    int          drop_wr = 0;
    int          wr_seen = 0;
    bit          pend = 0;
    int          pcnt = 0;
    logic [6:0]  paddr = '0;
    bit          pwe = 0;
    int          lock_dly = 100;
    bit          lock_auto = 1;
    int          lk_cnt = 0;
    logic        prev_rst = 1'b0;
    int          rel_cyc = 0, lock_rise_cyc = 0;
    int          done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
    logic        busy_at_done = 1'b0;
    int          n_checks = 0, n_fail = 0;
    logic [6:0]  w_addr[4];
    logic [15:0] w_data[4], w_mask[4];
    int          w_gap[4];

    function automatic logic [30:0] outs();
        return {drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst, busy, done, err, clk_ok,
                cfg_ready};
    endfunction

    // DRP slave: register image, drdy a fixed delay after each den
    initial begin
        drp_drdy = 1'b0;
        drp_do   = 16'd0;
        forever begin
            @(posedge clkin); #1;
            drp_drdy = 1'b0;
            drp_do   = 16'($urandom);
            if (pend) begin
                if (pcnt == 0) begin
                    drp_drdy = 1'b1;
                    if (!pwe) drp_do = mem[paddr];
                    drdy_q.push_back(cyc);
                    pend = 0;
                end else begin
                    pcnt--;
                end
            end
            if (drp_den) begin
                txn_t t;
                n_checks++;
                if (pend) begin
                    n_fail++;
                    $display("FAIL den_outstanding: den at cycle %0d while busy, want idle bus", cyc);
                end
                t.we = drp_dwe; t.addr = drp_daddr; t.di = drp_di; t.cyc = cyc;
                t.rst_hi = mmcm_rst;
                obs.push_back(t);
                pend = 1; pcnt = drdy_dly - 1; paddr = drp_daddr; pwe = drp_dwe;
                if (drp_dwe) begin
                    mem[drp_daddr] = drp_di;
                    wr_seen++;
                    if (wr_seen == drop_wr) pend = 0;
                end
            end
        end
    end

    // MMCM lock model: unlocked while in reset, locks lock_dly cycles after release
    initial begin
        mmcm_locked = 1'b0;
        forever begin
            @(posedge clkin); #1;
            if (prev_rst && !mmcm_rst) rel_cyc = cyc;
            if (lock_auto) begin
                if (mmcm_rst) begin
                    mmcm_locked = 1'b0;
                    lk_cnt = 0;
                end else if (!mmcm_locked && lock_dly > 0) begin
                    lk_cnt++;
                    if (lk_cnt >= lock_dly) begin
                        mmcm_locked = 1'b1;
                        lock_rise_cyc = cyc;
                    end
                end
            end
            prev_rst = mmcm_rst;
        end
    end

    initial begin
        forever begin
            @(posedge clkin); #1;
            if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
            if (err) begin err_cnt++; err_cyc = cyc; end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic present_word(input int i, input bit last, input int gap,
                                output int hs_cyc, output bit ok);
        ok = 0;
        hs_cyc = -1;
        repeat (gap) begin cfg_valid = 1'b0; @(posedge clkin); #1; end
        cfg_valid = 1'b1; cfg_addr = w_addr[i]; cfg_data = w_data[i];
        cfg_mask = w_mask[i]; cfg_last = last;
        for (int k = 0; k < 400; k++) begin
            if (cfg_ready) begin hs_cyc = cyc; ok = 1; break; end
            @(posedge clkin); #1;
        end
        @(posedge clkin); #1;
        cfg_valid = 1'b0;
        cfg_addr = 7'($urandom); cfg_data = 16'($urandom);
        cfg_mask = 16'($urandom); cfg_last = 1'($urandom);
    endtask

    task automatic run_seq(input int n, input bit last_flag, input bit exp_ok,
                           input int drop_i, input int budget);
        txn_t exp[$];
        txn_t t;
        int hs[4];
        int c0, d0, e0;
        bit ok, fin;
        obs.delete(); drdy_q.delete();
        wr_seen = 0; drop_wr = drop_i; d0 = done_cnt; e0 = err_cnt; fin = 0;
        for (int i = 0; i < n; i++) begin
            t.we = 0; t.addr = w_addr[i]; t.di = '0; t.cyc = 0; t.rst_hi = 1'b1;
            exp.push_back(t);
            exp_mem[w_addr[i]] = (exp_mem[w_addr[i]] & w_mask[i]) | (w_data[i] & ~w_mask[i]);
            t.we = 1; t.di = exp_mem[w_addr[i]];
            exp.push_back(t);
        end
        cfg_valid = 1'b1; cfg_addr = w_addr[0]; cfg_data = w_data[0];
        cfg_mask = w_mask[0]; cfg_last = last_flag && (n == 1);
        c0 = cyc;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL start_idle: busy=%b want 0", busy); end
        @(posedge clkin); #1;
        n_checks++;
        if ({mmcm_rst, busy} !== 2'b11) begin
            n_fail++; $display("FAIL start_hold: mmcm_rst,busy=%b want 11", {mmcm_rst, busy});
        end
        for (int i = 0; i < n; i++) begin
            present_word(i, last_flag && (i == n - 1), (i == 0) ? 0 : w_gap[i], hs[i], ok);
            n_checks++;
            if (!ok) begin
                n_fail++; $display("FAIL handshake_timeout: word %0d not accepted, want accepted", i);
                return;
            end
        end
        n_checks++;
        if (hs[0] != c0 + 1 + int'(RST_HOLD)) begin
            n_fail++; $display("FAIL ready_latency: ready at %0d want %0d", hs[0], c0 + 1 + RST_HOLD);
        end
        for (int k = 0; k < budget && !fin; k++) begin
            @(posedge clkin); #1;
            if (done || err) fin = 1;
        end
        n_checks++;
        if (!fin) begin n_fail++; $display("FAIL finish_timeout: got no done/err want one"); end
        @(posedge clkin); #1;
        if (exp_ok) begin
            n_checks++;
            if (clk_ok !== 1'b1) begin n_fail++; $display("FAIL clk_ok_after_done: got %b want 1", clk_ok); end
            n_checks++;
            if (done_cyc != lock_rise_cyc + 3) begin
                n_fail++; $display("FAIL done_latency: done at %0d want %0d", done_cyc, lock_rise_cyc + 3);
            end
            n_checks++;
            if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b want 0", busy_at_done); end
            n_checks++;
            if ({done_cnt - d0, err_cnt - e0} != {32'd1, 32'd0}) begin
                n_fail++; $display("FAIL pulse_count: done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0);
            end
        end else begin
            n_checks++;
            if ({done_cnt - d0, err_cnt - e0} != {32'd0, 32'd1}) begin
                n_fail++; $display("FAIL pulse_count: done %0d err %0d want 0 1", done_cnt - d0, err_cnt - e0);
            end
            n_checks++;
            if ({mmcm_rst, busy, clk_ok} !== 3'b100) begin
                n_fail++; $display("FAIL after_err: rst,busy,clk_ok=%b want 100", {mmcm_rst, busy, clk_ok});
            end
        end
        n_checks++;
        if (obs.size() != exp.size()) begin
            n_fail++; $display("FAIL txn_count: got %0d want %0d", obs.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            n_checks++;
            if ({obs[i].we, obs[i].addr} !== {exp[i].we, exp[i].addr}) begin
                n_fail++; $display("FAIL txn_kind[%0d]: we/addr %b/%h want %b/%h", i, obs[i].we,
                                   obs[i].addr, exp[i].we, exp[i].addr);
            end
            if (exp[i].we) begin
                n_checks++;
                if (obs[i].di !== exp[i].di) begin
                    n_fail++; $display("FAIL txn_wdata[%0d]: got %h want %h", i, obs[i].di, exp[i].di);
                end
                if (drdy_q.size() > i - 1) begin
                    n_checks++;
                    if (obs[i].cyc != drdy_q[i-1] + 2) begin
                        n_fail++; $display("FAIL wr_latency[%0d]: den at %0d want %0d", i, obs[i].cyc,
                                           drdy_q[i-1] + 2);
                    end
                end
            end else begin
                n_checks++;
                if (obs[i].cyc != hs[i/2] + 1) begin
                    n_fail++; $display("FAIL rd_latency[%0d]: den at %0d want %0d", i, obs[i].cyc,
                                       hs[i/2] + 1);
                end
            end
            n_checks++;
            if (obs[i].rst_hi !== 1'b1) begin
                n_fail++; $display("FAIL rst_held[%0d]: mmcm_rst %b want 1", i, obs[i].rst_hi);
            end
        end
    endtask

    task automatic rand_word(input int i);
        w_addr[i] = 7'($urandom); w_data[i] = 16'($urandom); w_mask[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        n_checks++;
        if (outs() !== 31'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", outs()); end
        rst = 1'b0;
        repeat (2) begin @(posedge clkin); #1; end
        n_checks++;
        if ({busy, cfg_ready, mmcm_rst, drp_den} !== 4'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {busy, cfg_ready, mmcm_rst, drp_den});
        end
    endtask

    task automatic test_single();
        w_addr[0] = 7'h08; w_data[0] = 16'h1041; w_mask[0] = 16'h1000;
        mem[8] = 16'hFFFF; exp_mem[8] = 16'hFFFF;
        drdy_dly = 2; lock_dly = 100;
        run_seq(1, 1, 1, 0, 2000);
        n_checks++;
        if (obs.size() < 2 || obs[1].di !== 16'h1041) begin
            n_fail++; $display("FAIL single_wdata: got %h want 1041", (obs.size() > 1) ? obs[1].di : 16'hx);
        end
    endtask

    task automatic test_multi();
        for (int i = 0; i < 3; i++) rand_word(i);
        w_gap[1] = 0; w_gap[2] = 5;
        drdy_dly = $urandom_range(1, 6);
        run_seq(3, 1, 1, 0, 2000);
    endtask

    task automatic test_drdy_timeout();
        rand_word(0); rand_word(1); w_gap[1] = $urandom_range(0, 3);
        drdy_dly = $urandom_range(1, 4);
        run_seq(2, 0, 0, 2, 400);
        n_checks++;
        if (obs.size() < 4 || err_cyc != obs[3].cyc + int'(DRDY_TIMEOUT) + 1) begin
            n_fail++; $display("FAIL drdy_err_latency: err at %0d want den+%0d", err_cyc, DRDY_TIMEOUT + 1);
        end
        drop_wr = 0; pend = 0;
        rand_word(0);
        run_seq(1, 1, 1, 0, 2000);
    endtask

    task automatic test_rst_mid();
        int hs, d0, e0;
        bit ok;
        rand_word(0); drdy_dly = 20; obs.delete(); wr_seen = 0;
        d0 = done_cnt; e0 = err_cnt;
        present_word(0, 1, 0, hs, ok);
        repeat (3) begin @(posedge clkin); #1; end
        n_checks++;
        if (obs.size() != 1 || drp_drdy) begin
            n_fail++; $display("FAIL rst_mid_setup: %0d txns want 1 read pending", obs.size());
        end
        rst = 1'b1; #1;
        n_checks++;
        if (outs() !== 31'd0) begin n_fail++; $display("FAIL rst_mid_async: got %h want 0", outs()); end
        @(posedge clkin); #1;
        n_checks++;
        if (outs() !== 31'd0) begin n_fail++; $display("FAIL rst_mid_held: got %h want 0", outs()); end
        rst = 1'b0; pend = 0;
        repeat (30) begin @(posedge clkin); #1; end
        n_checks++;
        if ({done_cnt - d0, err_cnt - e0} != {32'd0, 32'd0} || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_quiet: done %0d err %0d busy %b want 0 0 0",
                               done_cnt - d0, err_cnt - e0, busy);
        end
        drdy_dly = 2; rand_word(0);
        run_seq(1, 1, 1, 0, 2000);
    endtask

    task automatic test_idle_lock_drop();
        n_checks++;
        if (clk_ok !== 1'b1) begin n_fail++; $display("FAIL idle_pre: clk_ok %b want 1", clk_ok); end
        lock_auto = 0; mmcm_locked = 1'b0;
        repeat (3) begin @(posedge clkin); #1; end
        n_checks++;
        if ({clk_ok, busy, mmcm_rst} !== 3'b000) begin
            n_fail++; $display("FAIL lock_drop: clk_ok,busy,rst=%b want 000", {clk_ok, busy, mmcm_rst});
        end
        mmcm_locked = 1'b1;
        repeat (3) begin @(posedge clkin); #1; end
        n_checks++;
        if (clk_ok !== 1'b1) begin n_fail++; $display("FAIL lock_restore: clk_ok %b want 1", clk_ok); end
        lock_auto = 1;
    endtask

    task automatic test_lock_timeout();
        lock_dly = 0; drdy_dly = $urandom_range(1, 4); rand_word(0);
        run_seq(1, 1, 0, 0, LOCK_TIMEOUT + 2000);
        n_checks++;
        if (err_cyc != rel_cyc + int'(LOCK_TIMEOUT)) begin
            n_fail++; $display("FAIL lock_err_latency: err at %0d want %0d", err_cyc, rel_cyc + LOCK_TIMEOUT);
        end
        lock_dly = 100;
    endtask

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_mask = '0; cfg_last = 1'b0;
        for (int i = 0; i < 128; i++) begin mem[i] = 16'hFFFF; exp_mem[i] = 16'hFFFF; end
        for (int i = 0; i < 4; i++) w_gap[i] = 0;
        repeat (3) @(posedge clkin);
        #1;
        test_reset();
        test_single();
        test_multi();
        test_drdy_timeout();
        test_rst_mid();
        test_idle_lock_drop();
        test_lock_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mmcm_drp_ctrl.md
# mmcm_drp_ctrl

Runtime reconfiguration sequencer for the board's MMCME2 clock generator, clocked from the free-running 125 MHz board clock, never from the MMCM output. It accepts a stream of masked register writes from a requester. It holds the MMCM in reset, applies each write as a DRP read-modify-write, then releases reset and waits for lock. Status is reported as `busy`/`done`/`err`, and `clk_ok` qualifies the generated clock for downstream logic.

## Interface
Parameters:
- `RST_HOLD`, 4: cycles `mmcm_rst` is held before the first DRP access; legal range 3..255.
- `DRDY_TIMEOUT`, 64: maximum cycles from a `drp_den` pulse to `drp_drdy`.
- `LOCK_TIMEOUT`, 65536: maximum cycles from reset release to synchronized lock.

Ports (one clock; reset is asynchronous and active-high):
- `clkin`  in  1: board clock, 125 MHz.
- `rst`  in  1: asynchronous, active-high reset.
- `cfg_valid`  in  1: write word available.
- `cfg_ready`  out  1: word accepted when `cfg_valid & cfg_ready`.
- `cfg_addr`  in  7: DRP register address.
- `cfg_data`  in  16: new bit values.
- `cfg_mask`  in  16: 1 = keep the existing bit, 0 = take the bit from `cfg_data`.
- `cfg_last`  in  1: final word of the sequence.
- `drp_den`  out  1: DRP enable, single-cycle pulse.
- `drp_dwe`  out  1: DRP write enable, valid with `drp_den`.
- `drp_daddr`  out  7: DRP address.
- `drp_di`  out  16: DRP write data.
- `drp_do`  in  16: DRP read data, valid with `drp_drdy`.
- `drp_drdy`  in  1: DRP transaction complete.
- `mmcm_rst`  out  1: MMCM RST pin.
- `mmcm_locked`  in  1: MMCM LOCKED, asynchronous to `clkin`.
- `busy`  out  1: a sequence is in progress.
- `done`  out  1: one-cycle pulse on successful lock.
- `err`  out  1: one-cycle pulse on any timeout.
- `clk_ok`  out  1: generated clock usable.

## Operation
- `mmcm_locked` passes through a 2-FF synchronizer to give `lock_s`.
- States: IDLE, HOLD, WAIT_WORD, RD, RD_WAIT, WR, WR_WAIT, WAIT_LOCK.
- IDLE:
  - `busy`=0 and `cfg_ready`=0.
  - `cfg_valid`=1 moves to HOLD, sets `mmcm_rst`=1 and loads the hold counter.
- HOLD: `busy`=1. After `RST_HOLD` cycles, move to WAIT_WORD.
- WAIT_WORD:
  - `cfg_ready`=1.
  - On handshake, latch addr/data/mask/last and move to RD.
- RD:
  - One cycle with `drp_den`=1, `drp_dwe`=0, `drp_daddr`=addr.
  - Load the DRDY timer, then move to RD_WAIT.
- RD_WAIT: on `drp_drdy`, latch `merged = (drp_do & mask) | (data & ~mask)` and move to WR.
- WR:
  - One cycle with `drp_den`=1, `drp_dwe`=1, `drp_di`=merged.
  - Move to WR_WAIT.
- WR_WAIT, on `drp_drdy`:
  - If last: clear `mmcm_rst` (0), load the lock timer and move to WAIT_LOCK.
  - Otherwise: move to WAIT_WORD.
- WAIT_LOCK: `lock_s`=1 pulses `done` and moves to IDLE.
- Timeouts:
  - DRDY timer expires in RD_WAIT or WR_WAIT: pulse `err` and move to IDLE with `mmcm_rst` left at 1.
  - Lock timer expires: pulse `err`, set `mmcm_rst` to 1 and move to IDLE.
- `clk_ok` = `lock_s` & IDLE & `!mmcm_rst`, registered.
- `drp_den` is never asserted while a DRP transaction is outstanding.
- A new sequence is never started outside IDLE.
- `cfg_valid` is ignored outside IDLE and WAIT_WORD.

## Timing
- Reset values:
  - All outputs are 0: `mmcm_rst`=0, so the MMCM runs its bitstream configuration.
  - State is IDLE and the synchronizer is cleared.
- Asserting `rst` mid-sequence aborts immediately:
  - `drp_den`=0 and `mmcm_rst`=0.
  - No `done` or `err` pulse.
- `cfg_valid` high in IDLE at cycle 0 gives:
  - `mmcm_rst`=1 and `busy`=1 at cycle 1.
  - `cfg_ready`=1 at cycle 1+`RST_HOLD`.
- Handshake at cycle n gives `drp_den` (read) at n+1.
- `drp_drdy` at cycle m gives `drp_den` (write) at m+2.
- The DRDY timer counts cycles after `drp_den`:
  - `drp_drdy` on cycle `DRDY_TIMEOUT` is accepted.
  - No `drp_drdy` by then pulses `err` on the next cycle.
- `drp_drdy` arriving in the same cycle as timer expiry counts as success.
- `lock_s` at cycle k gives `done`=1 and `busy`=0 at k+1, and `clk_ok`=1 at k+2.
- A stale high `lock_s` cannot be seen in WAIT_LOCK: `RST_HOLD` ≥ 3 guarantees the synchronizer has flushed low.
- `lock_s` dropping while in IDLE clears `clk_ok` within 1 cycle. No automatic retry.

## Test plan
- Single word: addr 0x08, data 0x1041, mask 0x1000, `drp_do`=0xFFFF with `drp_drdy` 2 cycles after each `drp_den`, lock 100 cycles after release.
  - Expect a read then a write to 0x08 with `drp_di`=0x1041.
  - Expect `mmcm_rst` high throughout, one `done` pulse, and `clk_ok`=1.
- Three-word sequence with `cfg_valid` gaps of 0 and 5 cycles → exactly 3 reads and 3 writes in order, then one `done`.
- DRDY never returns on the second write → `err` pulse 65 cycles after that write's `drp_den`.
  - `mmcm_rst` stays 1, `busy`=0 and `clk_ok`=0.
  - A following sequence completes normally.
- `mmcm_locked` held low → `err` after 65536 cycles, `mmcm_rst`=1 and `clk_ok`=0.
- `rst` pulsed during RD_WAIT → all outputs 0 within the reset assertion and no `err`.
  - A new request afterward starts from HOLD.
- `mmcm_locked` deasserted in IDLE → `clk_ok` falls within 3 cycles. Reasserting it restores `clk_ok`.
